// File: rtl/systolic_loader_pkg.sv
// Shared definitions for the systolic array feeder and its downstream peers.
package systolic_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int FRAME_LEN   = 8;
    localparam int IDX_A_LAST  = 3;
    localparam int TIMEOUT_DEF = 15;
    localparam int IDX_W       = 3;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // True when the operand index points at the final byte slot of a frame.
    function automatic logic is_frame_end(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(FRAME_LEN - 1);
    endfunction

endpackage

// File: rtl/systolic_loader_if.sv
// Byte-stream handshake feeding the systolic loader.
interface systolic_loader_if
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/systolic_loader.sv
// Assembles an 8-byte frame (A row-major, then B row-major) into held
// operand registers, launches the 2x2 systolic array and supervises it.
module systolic_loader
    import systolic_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    systolic_loader_if.slave  s,
    output logic [DATA_W-1:0] A00,
    output logic [DATA_W-1:0] A01,
    output logic [DATA_W-1:0] A10,
    output logic [DATA_W-1:0] A11,
    output logic [DATA_W-1:0] B00,
    output logic [DATA_W-1:0] B01,
    output logic [DATA_W-1:0] B10,
    output logic [DATA_W-1:0] B11,
    output logic              start,
    input  logic              arr_done,
    output logic              busy,
    output logic              mat_done,
    output logic              frame_err,
    output logic              timeout_err
);

    localparam int B_BASE = IDX_A_LAST + 1;

    state_t                            state_r;
    logic [IDX_W-1:0]                  idx_r;
    logic [CNT_W-1:0]                  cnt_r;
    logic [FRAME_LEN-1:0][DATA_W-1:0]  ops_r;
    logic                              start_r;
    logic                              busy_r;
    logic                              mat_done_r;
    logic                              frame_err_r;
    logic                              timeout_err_r;
    logic                              accept_s;
    logic                              tmo_hit_s;

    // Only LOAD takes bytes; no buffering exists beyond the operand file.
    assign s.in_ready = (state_r == ST_LOAD);
    assign accept_s   = s.in_valid && (state_r == ST_LOAD);
    assign tmo_hit_s  = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Frame assembly, launch pulse and completion/timeout sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_LOAD;
            idx_r         <= '0;
            cnt_r         <= '0;
            ops_r         <= '0;
            start_r       <= 1'b0;
            busy_r        <= 1'b0;
            mat_done_r    <= 1'b0;
            frame_err_r   <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            start_r       <= 1'b0;
            mat_done_r    <= 1'b0;
            frame_err_r   <= 1'b0;
            timeout_err_r <= 1'b0;
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) begin
                        // The byte is stored even if the frame turns out bad;
                        // a bad frame simply never reaches FIRE.
                        ops_r[idx_r] <= s.in_data;
                        if (is_frame_end(idx_r)) begin
                            idx_r <= '0;
                            if (s.in_last) begin
                                state_r <= ST_FIRE;
                                start_r <= 1'b1;
                                busy_r  <= 1'b1;
                            end else begin
                                frame_err_r <= 1'b1;
                            end
                        end else if (s.in_last) begin
                            idx_r       <= '0;
                            frame_err_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                ST_FIRE: begin
                    state_r <= ST_WAIT;
                    cnt_r   <= '0;
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    // Done takes priority over a coincident timeout.
                    if (arr_done) begin
                        mat_done_r <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= ST_LOAD;
                    end else if (tmo_hit_s) begin
                        timeout_err_r <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= ST_LOAD;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                    idx_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign A00         = ops_r[0];
    assign A01         = ops_r[1];
    assign A10         = ops_r[2];
    assign A11         = ops_r[IDX_A_LAST];
    assign B00         = ops_r[B_BASE];
    assign B01         = ops_r[B_BASE + 1];
    assign B10         = ops_r[B_BASE + 2];
    assign B11         = ops_r[B_BASE + 3];
    assign start       = start_r;
    assign busy        = busy_r;
    assign mat_done    = mat_done_r;
    assign frame_err   = frame_err_r;
    assign timeout_err = timeout_err_r;

endmodule
